// File: rtl/gbc_flash_pkg.sv
// Shared types and constants for the NOR flash read path.
// Holds the state encoding, address width and default wait-state count.
package gbc_flash_pkg;

  localparam int FLASH_ADDR_W   = 24;
  localparam int FLASH_WAIT_DEF = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_PREFETCH = 2'd2
  } flash_st_e;

endpackage

// File: rtl/flash_wait_counter.sv
// Loadable down-counter for flash access wait states.
// Ports: I_CLK, I_RESET (async high), I_LOAD/I_LOAD_VAL, I_EN, O_ZERO.
module flash_wait_counter #(
  parameter int W = 4
) (
  input  logic         I_CLK,
  input  logic         I_RESET,
  input  logic         I_LOAD,
  input  logic [W-1:0] I_LOAD_VAL,
  input  logic         I_EN,
  output logic         O_ZERO
);

  logic [W-1:0] cnt;

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET)
      cnt <= '0;
    else if (I_LOAD)
      cnt <= I_LOAD_VAL;
    else if (I_EN && cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign O_ZERO = (cnt == '0);

endmodule

// File: rtl/flash_read_ctrl.sv
// Cartridge-to-NOR-flash read timing controller with registered data/ACK.
// Ports: I_CLK, I_RESET, I_REQ/I_ADDR in, O_ACK/O_DATA/O_BUSY out, flash
// pins out, I_FLASH_DATA in. `define FLASH_PREFETCH_EN adds a one-word
// sequential prefetch buffer.
module flash_read_ctrl
  import gbc_flash_pkg::*;
#(
  parameter int P_WAIT_CYCLES = FLASH_WAIT_DEF,
  parameter int P_ADDR_W      = FLASH_ADDR_W
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  input  logic                I_REQ,
  input  logic [P_ADDR_W-1:0] I_ADDR,
  output logic                O_ACK,
  output logic [7:0]          O_DATA,
  output logic                O_BUSY,
  output logic [P_ADDR_W-1:0] O_FLASH_ADDR,
  input  logic [15:0]         I_FLASH_DATA,
  output logic                O_FLASH_CE_L,
  output logic                O_FLASH_OE_L,
  output logic                O_FLASH_WE_L,
  output logic                O_FLASH_CLK,
  output logic                O_ADDR_VALID_L
);

  localparam logic [CNT_W-1:0] WAIT_LD =
    CNT_W'(P_WAIT_CYCLES - 1);

  flash_st_e state, state_n;

  logic                start;
  logic                done;
  logic                cnt_zero;
  logic                cnt_load;
  logic                cnt_en;
  logic [P_ADDR_W-1:0] ld_addr;
  logic                unused_hi;

`ifdef FLASH_PREFETCH_EN
  logic                hit;
  logic                pf_start;
  logic                pf_fill;
  logic                conv_set;
  logic                conv;
  logic                pf_valid;
  logic [P_ADDR_W-1:0] pf_addr;
  logic [P_ADDR_W-1:0] ack_addr;
  logic [7:0]          pf_data;
`endif

  assign unused_hi = ^I_FLASH_DATA[15:8];

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

`ifdef FLASH_PREFETCH_EN
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    done     = 1'b0;
    hit      = 1'b0;
    pf_start = 1'b0;
    pf_fill  = 1'b0;
    conv_set = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (I_REQ) begin
          if (pf_valid && I_ADDR == pf_addr) begin
            hit = 1'b1;
          end else begin
            start   = 1'b1;
            state_n = ST_WAIT;
          end
        end else if (O_ACK) begin
          pf_start = 1'b1;
          state_n  = ST_PREFETCH;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_PREFETCH: begin
        // A different address kills the prefetch and starts the
        // demand read at this same edge.
        if (I_REQ && !conv && I_ADDR != pf_addr) begin
          start   = 1'b1;
          state_n = ST_WAIT;
        end else if (cnt_zero) begin
          state_n = ST_IDLE;
          if (conv || I_REQ)
            done = 1'b1;
          else
            pf_fill = 1'b1;
        end else if (I_REQ) begin
          conv_set = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign cnt_load = start | pf_start;
  assign ld_addr  = start ? I_ADDR
                          : ack_addr + P_ADDR_W'(1);
`else
  always_comb begin
    state_n = state;
    start   = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (I_REQ) begin
          start   = 1'b1;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign cnt_load = start;
  assign ld_addr  = I_ADDR;
`endif

  always_comb begin
    O_BUSY         = 1'b0;
    O_FLASH_CE_L   = 1'b1;
    O_FLASH_OE_L   = 1'b1;
    O_ADDR_VALID_L = 1'b1;
    unique case (state)
      ST_WAIT, ST_PREFETCH: begin
        O_BUSY         = 1'b1;
        O_FLASH_CE_L   = 1'b0;
        O_FLASH_OE_L   = 1'b0;
        O_ADDR_VALID_L = 1'b0;
      end
      default: ;
    endcase
  end

  assign O_FLASH_WE_L = 1'b1;
  assign O_FLASH_CLK  = 1'b1;
  assign cnt_en       = (state != ST_IDLE);

  flash_wait_counter #(.W(CNT_W)) u_cnt (
    .I_CLK      (I_CLK),
    .I_RESET    (I_RESET),
    .I_LOAD     (cnt_load),
    .I_LOAD_VAL (WAIT_LD),
    .I_EN       (cnt_en),
    .O_ZERO     (cnt_zero)
  );

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      O_FLASH_ADDR <= '0;
      O_ACK        <= 1'b0;
      O_DATA       <= '0;
    end else begin
`ifdef FLASH_PREFETCH_EN
      O_ACK <= done | hit;
      if (hit)
        O_DATA <= pf_data;
`else
      O_ACK <= done;
`endif
      if (cnt_load)
        O_FLASH_ADDR <= ld_addr;
      if (done)
        O_DATA <= I_FLASH_DATA[7:0];
    end
  end

`ifdef FLASH_PREFETCH_EN
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      pf_valid <= 1'b0;
      pf_addr  <= '0;
      pf_data  <= '0;
      ack_addr <= '0;
      conv     <= 1'b0;
    end else begin
      if (pf_start) begin
        pf_valid <= 1'b0;
        pf_addr  <= ld_addr;
      end else if (pf_fill) begin
        pf_valid <= 1'b1;
        pf_data  <= I_FLASH_DATA[7:0];
      end else if (hit || (start && state == ST_PREFETCH)) begin
        pf_valid <= 1'b0;
      end
      if (done)
        ack_addr <= O_FLASH_ADDR;
      else if (hit)
        ack_addr <= pf_addr;
      if (state_n != ST_PREFETCH)
        conv <= 1'b0;
      else if (conv_set)
        conv <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Self-checking bench for flash_read_ctrl with a timed NOR flash model.
// Prefetch scenarios run only when FLASH_PREFETCH_EN is defined.
module tb_flash_read_ctrl;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [23:0] addr;
  logic        ack;
  logic [7:0]  dout;
  logic        busy;
  logic [23:0] faddr;
  logic [15:0] fdata = 16'h0BAD;
  logic        ce_l, oe_l, we_l, fclk, av_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flash_read_ctrl #(
    .P_WAIT_CYCLES (P),
    .P_ADDR_W      (24)
  ) dut (
    .I_CLK          (clk),
    .I_RESET        (rst),
    .I_REQ          (req),
    .I_ADDR         (addr),
    .O_ACK          (ack),
    .O_DATA         (dout),
    .O_BUSY         (busy),
    .O_FLASH_ADDR   (faddr),
    .I_FLASH_DATA   (fdata),
    .O_FLASH_CE_L   (ce_l),
    .O_FLASH_OE_L   (oe_l),
    .O_FLASH_WE_L   (we_l),
    .O_FLASH_CLK    (fclk),
    .O_ADDR_VALID_L (av_l)
  );

  function automatic logic [15:0] fmem(input logic [23:0] a);
    if (a == 24'h008123)
      return 16'hA55A;
    return {a[7:0] ^ a[23:16], a[15:8] ^ a[7:0] ^ 8'h3C};
  endfunction

  // Flash drives valid data only after P cycles of CE low on one address.
  int          lo_cnt = 0;
  logic [23:0] paddr  = '0;
  always @(negedge clk) begin
    if (!ce_l) begin
      if (faddr == paddr && lo_cnt > 0)
        lo_cnt++;
      else
        lo_cnt = 1;
    end else begin
      lo_cnt = 0;
    end
    paddr = faddr;
    fdata = (lo_cnt >= P) ? fmem(faddr) : 16'h0BAD;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Issue one read; exp_n = negedge index (after the sampling edge)
  // on which ACK must first be seen.
  task automatic rd(input logic [23:0] a,
                    input int exp_n,
                    input bit b2b);
    logic [15:0] w;
    int  n;
    int  lo;
    bit  got;
    w    = fmem(a);
    req  = 1'b1;
    addr = a;
    @(posedge clk);
    n   = 0;
    lo  = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack) begin
        got = 1'b1;
        chk("ack_lat", n, exp_n);
        chk("ack_data", dout, w[7:0]);
        chk("ack_busy", busy, 0);
        chk("ack_ce", ce_l, 1);
        if (exp_n == P + 1)
          chk("ce_low_cycles", lo, P);
      end else begin
        if (!ce_l)
          lo++;
        chk("wait_addr", faddr, a);
        chk("wait_busy", busy, 1);
        chk("wait_oe", oe_l, 0);
        req  = 1'($urandom);
        addr = 24'($urandom);
      end
    end
    if (!got)
      chk("ack_timeout", 0, 1);
    if (!b2b) begin
      req = 1'b0;
      @(negedge clk);
      chk("ack_pulse", ack, 0);
    end
  endtask

  initial begin
    logic [23:0] a;
    logic [23:0] prev;
    int          acks;
    int          gap;

    rst  = 1'b1;
    req  = 1'b0;
    addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_data", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_faddr", faddr, 0);
    chk("rst_ce", ce_l, 1);
    chk("rst_oe", oe_l, 1);
    chk("rst_av", av_l, 1);
    chk("tie_we", we_l, 1);
    chk("tie_clk", fclk, 1);
    rst = 1'b0;
    @(negedge clk);

    rd(24'h008123, P + 1, 1'b0);
    chk("single_byte", dout, 8'h5A);
    repeat (10) @(negedge clk);

    req  = 1'b1;
    addr = 24'h000777;
    @(posedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ack", ack, 0);
    chk("abort_data", dout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ce", ce_l, 1);
    chk("abort_faddr", faddr, 0);
    @(negedge clk);
    rst  = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack)
        acks++;
    end
    chk("abort_no_ack", acks, 0);

    rd(24'h000100, P + 1, 1'b1);
    rd(24'h000200, P + 1, 1'b0);
    rd(24'h000000, P + 1, 1'b0);
    rd(24'hFFFFFF, P + 1, 1'b0);
    repeat (10) @(negedge clk);

`ifdef FLASH_PREFETCH_EN
    rd(24'h004000, P + 1, 1'b0);
    repeat (8) @(negedge clk);
    rd(24'h004001, 1, 1'b0);
    rd(24'hFFFFFF, P + 1, 1'b0);
    repeat (8) @(negedge clk);
    rd(24'h000000, 1, 1'b0);
    repeat (8) @(negedge clk);
    rd(24'h000010, P + 1, 1'b0);
    rd(24'h000500, P + 1, 1'b0);
    rd(24'h000020, P + 1, 1'b0);
    rd(24'h000021, P, 1'b0);
    repeat (10) @(negedge clk);
`endif

    prev = 24'h000021;
    for (int i = 0; i < 30; i++) begin
      do begin
        if ($urandom_range(0, 7) == 0)
          a = 24'hFFFFFF;
        else
          a = 24'($urandom);
      end while (a == prev + 24'd1);
      gap = $urandom_range(0, 3);
      rd(a, P + 1, gap == 0);
      if (gap > 1)
        repeat (gap - 1) @(negedge clk);
      prev = a;
    end
    req = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
